// File: rtl/tetris_field_buffer_if.sv
// -----------------------------------------------------------------------------
// tetris_field_buffer_if
//
// Bundles every non-clock signal of tetris_field_buffer:
//   renderer side : x_coord, y_coord, draw_finish -> coord_value
//   game side     : wr_req/wr_x/wr_y/wr_val -> wr_ack
//                   clr_req/clr_row         -> clr_done
//                   commit_req              -> commit_done
//   status        : busy, dbg_state (raw FSM state for observation)
//   optional      : row_full[FIELD_H-1:0], present only when FIELD_ROW_FULL_EN
//                   is defined.
//
// Handshake: a request (wr_req, clr_req, commit_req) is level-held by the
// requester and is taken only while the buffer is idle; the buffer answers with
// a one-cycle pulse (wr_ack, clr_done, commit_done) in the cycle after the
// completing edge, after which the requester drops or re-issues its request.
//
// Modports: slave = the field buffer, master = game logic + renderer.
// -----------------------------------------------------------------------------
interface tetris_field_buffer_if
`ifdef FIELD_ROW_FULL_EN
#(
    parameter int FIELD_H = 20
)
`endif
;
    // Renderer read port
    logic [7:0] x_coord;
    logic [7:0] y_coord;
    logic       coord_value;
    logic       draw_finish;

    // Back-buffer write port
    logic       wr_req;
    logic [3:0] wr_x;
    logic [4:0] wr_y;
    logic       wr_val;
    logic       wr_ack;

    // Row clear
    logic       clr_req;
    logic [4:0] clr_row;
    logic       clr_done;

    // Commit
    logic       commit_req;
    logic       commit_done;

    // Status
    logic       busy;
    logic [1:0] dbg_state;

`ifdef FIELD_ROW_FULL_EN
    logic [FIELD_H-1:0] row_full;
`endif

    modport slave (
        input  x_coord, y_coord, draw_finish,
        input  wr_req, wr_x, wr_y, wr_val,
        input  clr_req, clr_row,
        input  commit_req,
        output coord_value, wr_ack, clr_done, commit_done, busy, dbg_state
`ifdef FIELD_ROW_FULL_EN
        , output row_full
`endif
    );

    modport master (
        output x_coord, y_coord, draw_finish,
        output wr_req, wr_x, wr_y, wr_val,
        output clr_req, clr_row,
        output commit_req,
        input  coord_value, wr_ack, clr_done, commit_done, busy, dbg_state
`ifdef FIELD_ROW_FULL_EN
        , input row_full
`endif
    );

endinterface

// File: rtl/tetris_field_buffer.sv
// -----------------------------------------------------------------------------
// tetris_field_buffer
//
// Double-buffered Tetris playfield. The game edits a private back buffer (cell
// writes and row clears); a commit copies the whole back buffer into the front
// buffer on the renderer's draw_finish pulse, so a frame never shows a
// half-applied move. The renderer reads the front buffer combinationally.
//
// Ports:
//   vga_clk  in  sole clock, rising edge
//   rst_n    in  synchronous active-low reset (clears both buffers, FSM idle)
//   bus      slave modport of tetris_field_buffer_if:
//     x_coord/y_coord in, coord_value out  : front[y][x], 0 when out of range
//     draw_finish in                       : end-of-frame pulse
//     wr_req/wr_x/wr_y/wr_val in, wr_ack   : back-buffer cell write
//     clr_req/clr_row in, clr_done         : remove a row, rows above drop by 1
//     commit_req in, commit_done           : publish back buffer at next frame
//     busy out                             : FSM not idle
//     dbg_state out                        : raw FSM state
//     row_full out (FIELD_ROW_FULL_EN only): per-row all-ones flag of back
//
// Optional feature macro: FIELD_ROW_FULL_EN.
// -----------------------------------------------------------------------------
module tetris_field_buffer #(
    parameter int FIELD_W = 10,
    parameter int FIELD_H = 20
) (
    input  logic                    vga_clk,
    input  logic                    rst_n,
    tetris_field_buffer_if.slave    bus
);

    // Range limits sized to the port that is compared against them.
    localparam logic [7:0] RD_W_LIM  = 8'(FIELD_W);
    localparam logic [7:0] RD_H_LIM  = 8'(FIELD_H);
    localparam logic [3:0] WR_W_LIM  = 4'(FIELD_W);
    localparam logic [4:0] WR_H_LIM  = 5'(FIELD_H);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT      = 2'd1,
        WAIT_FRAME = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               wr_ack_q, wr_ack_d;
    logic               clr_done_q, clr_done_d;
    logic               commit_done_q, commit_done_d;

    logic [FIELD_W-1:0] front_q [FIELD_H];
    logic [FIELD_W-1:0] front_d [FIELD_H];
    logic [FIELD_W-1:0] back_q  [FIELD_H];
    logic [FIELD_W-1:0] back_d  [FIELD_H];

    logic               wr_in_range;
    logic               clr_in_range;
    logic               rd_in_range;

    assign wr_in_range  = (bus.wr_x < WR_W_LIM) && (bus.wr_y < WR_H_LIM);
    assign clr_in_range = (bus.clr_row < WR_H_LIM);
    assign rd_in_range  = (bus.x_coord < RD_W_LIM) && (bus.y_coord < RD_H_LIM);

    // -------------------------------------------------------------------------
    // Next-state logic: FSM plus buffer edits.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_ack_d      = 1'b0;
        clr_done_d    = 1'b0;
        commit_done_d = 1'b0;
        back_d        = back_q;
        front_d       = front_q;

        case (state_q)
            IDLE: begin
                // Fixed priority: clear > commit > write. Losers are simply
                // not taken this cycle; their requesters keep holding.
                if (bus.clr_req) begin
                    if (clr_in_range) begin
                        cnt_d   = bus.clr_row;
                        state_d = SHIFT;
                    end else begin
                        // Nothing to remove, finish immediately.
                        clr_done_d = 1'b1;
                    end
                end else if (bus.commit_req) begin
                    state_d = WAIT_FRAME;
                end else if (bus.wr_req) begin
                    // Out-of-range writes are acknowledged but dropped.
                    wr_ack_d = 1'b1;
                    if (wr_in_range) begin
                        back_d[bus.wr_y][bus.wr_x] = bus.wr_val;
                    end
                end
            end

            SHIFT: begin
                // Walk from the cleared row up to the top, pulling each row
                // down from the one above; the top row becomes empty.
                if (cnt_q != 5'd0) begin
                    back_d[cnt_q] = back_q[cnt_q - 5'd1];
                    cnt_d         = cnt_q - 5'd1;
                end else begin
                    back_d[0]  = '0;
                    clr_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end

            WAIT_FRAME: begin
                // Whole-field copy happens on the frame boundary only.
                if (bus.draw_finish) begin
                    front_d       = back_q;
                    commit_done_d = 1'b1;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers. Reset abandons any operation in flight without a done.
    // -------------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wr_ack_q      <= 1'b0;
            clr_done_q    <= 1'b0;
            commit_done_q <= 1'b0;
            for (int r = 0; r < FIELD_H; r++) begin
                front_q[r] <= '0;
                back_q[r]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_ack_q      <= wr_ack_d;
            clr_done_q    <= clr_done_d;
            commit_done_q <= commit_done_d;
            for (int r = 0; r < FIELD_H; r++) begin
                front_q[r] <= front_d[r];
                back_q[r]  <= back_d[r];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Unregistered read: the renderer samples in the same cycle it presents
    // the coordinate.
    assign bus.coord_value = rd_in_range ?
                             front_q[bus.y_coord[4:0]][bus.x_coord[3:0]] : 1'b0;

    assign bus.wr_ack      = wr_ack_q;
    assign bus.clr_done    = clr_done_q;
    assign bus.commit_done = commit_done_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.dbg_state   = state_q;

`ifdef FIELD_ROW_FULL_EN
    // Gated by rst_n so the flags read 0 for the whole time reset is held,
    // not just after the first reset edge.
    for (genvar r = 0; r < FIELD_H; r++) begin : g_row_full
        assign bus.row_full[r] = rst_n & (&back_q[r]);
    end
`endif

endmodule
